// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the 101 framer transmitter and the 101 sequence
// detectors downstream of it.
//   state_e   : framer FSM states
//   PREAMBLE  : 3-bit frame marker, sent MSB first. The detector uses the
//               same value as its match pattern.
//   PRE_LEN   : number of preamble bits
//   cnt_width : width of a down-counter that must hold max(a, b, PRE_LEN)-1
// ---------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_e;

    localparam logic [2:0] PREAMBLE = 3'b101;
    localparam int         PRE_LEN  = 3;

    // The counter loads N-1 for a phase of N cycles. clog2(max) is therefore
    // always enough, and it is at least 2 because PRE_LEN is 3.
    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        m = (m > PRE_LEN) ? m : PRE_LEN;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/piso_shift.sv
// ---------------------------------------------------------------------------
// piso_shift
// WIDTH-bit parallel-in, serial-out shift register, MSB first.
//   clk     : rising-edge clock
//   reset   : asynchronous, active-low clear
//   load    : capture data_in (takes priority over shift)
//   shift   : move every bit one place toward the MSB, zero fills the LSB
//   data_in : parallel word
//   msb     : current MSB, the next bit to transmit
// ---------------------------------------------------------------------------
module piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data_in,
    output logic             msb
);

    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] sr_q;

    // NOTE: every variable assigned in an always_comb gets a default on the
    // first line, so no path through the block can leave it unassigned and
    // infer a latch.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = data_in;
        end else if (shift) begin
            sr_d = sr_q << 1;
        end
    end

    // NOTE: flops are written with non-blocking assignments only. Every
    // register then updates from the values that held before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/seq_101_framer_tx.sv
// ---------------------------------------------------------------------------
// seq_101_framer_tx
// Serial transmitter. It sends the "101" preamble, then a WIDTH-bit word MSB
// first, then GAP_CYCLES idle zeros. After that it spends one IDLE cycle
// before it accepts the next word.
//   clk     : rising-edge clock
//   reset   : asynchronous, active-low reset
//   data_in : word to send. It is sampled only on the accept edge.
//   valid   : data_in is valid. The word is accepted when valid and ready
//             are both high at a clock edge.
//   ready   : high only in IDLE
//   out     : registered serial line. It is 0 in IDLE and in the gap.
//   busy    : high from accept until the return to IDLE
//   done    : one-cycle pulse while data bit 0 is on out
// ---------------------------------------------------------------------------
module seq_101_framer_tx
    import seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             out,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = cnt_width(WIDTH, GAP_CYCLES);

    // Each phase loads its length minus one. The terminal count of zero
    // selects the next state, so the counter never wraps.
    localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [CNT_W-1:0] cnt_dec;
    logic             out_d, out_q;
    logic             done_d, done_q;
    logic             ready_d, ready_q;
    logic             busy_d, busy_q;

    logic             sr_load;
    logic             sr_shift;
    logic             sr_msb;

    piso_shift #(
        .WIDTH (WIDTH)
    ) u_piso_shift (
        .clk     (clk),
        .reset   (reset),
        .load    (sr_load),
        .shift   (sr_shift),
        .data_in (data_in),
        .msb     (sr_msb)
    );

    assign cnt_dec = cnt_q - 1'b1;

    // The next-state logic also computes the value that out takes after the
    // edge. Every output is then a flop, and valid has no combinational path
    // to out.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = 1'b0;
        done_d   = 1'b0;
        sr_load  = 1'b0;
        sr_shift = 1'b0;

        case (state_q)
            IDLE: begin
                // ready is high throughout IDLE, so valid alone accepts.
                if (valid) begin
                    state_d = PRE;
                    cnt_d   = PRE_LOAD;
                    out_d   = PREAMBLE[PRE_LEN-1];
                    sr_load = 1'b1;
                end
            end

            PRE: begin
                if (cnt_q == '0) begin
                    // The first data bit goes out on the edge that enters DATA.
                    state_d  = DATA;
                    cnt_d    = DATA_LOAD;
                    out_d    = sr_msb;
                    sr_shift = 1'b1;
                    done_d   = (DATA_LOAD == '0);
                end else begin
                    // The count after decrement indexes the preamble bit
                    // that goes out next.
                    cnt_d = cnt_dec;
                    out_d = PREAMBLE[cnt_dec[1:0]];
                end
            end

            DATA: begin
                if (cnt_q == '0) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d    = cnt_dec;
                    out_d    = sr_msb;
                    sr_shift = 1'b1;
                    done_d   = (cnt_dec == '0);
                end
            end

            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_dec;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign out   = out_q;
    assign done  = done_q;

endmodule

// File: tb/tb_seq_101_framer_tx.sv
// ---------------------------------------------------------------------------
// tb_seq_101_framer_tx
// Directed bench for seq_101_framer_tx. u_dut uses WIDTH=8 and GAP_CYCLES=2.
// u_dut0 uses GAP_CYCLES=0 and feeds a small 101-detector model.
// Outputs are compared as a packed {out, done, ready, busy} nibble.
// ---------------------------------------------------------------------------
module tb_seq_101_framer_tx;
    import seq_pkg::*;

    localparam int W      = 8;
    localparam int GAP    = 2;
    localparam int PERIOD = PRE_LEN + W + GAP;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] data_in;
    logic         valid;
    logic         ready, out, busy, done;

    logic [W-1:0] data0;
    logic         valid0;
    logic         ready0, out0, busy0, done0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_101_framer_tx #(.WIDTH(W), .GAP_CYCLES(GAP)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .valid   (valid),
        .ready   (ready),
        .out     (out),
        .busy    (busy),
        .done    (done)
    );

    seq_101_framer_tx #(.WIDTH(W), .GAP_CYCLES(0)) u_dut0 (
        .clk     (clk),
        .reset   (reset),
        .data_in (data0),
        .valid   (valid0),
        .ready   (ready0),
        .out     (out0),
        .busy    (busy0),
        .done    (done0)
    );

    typedef struct {
        logic         valid;
        logic [W-1:0] data;
        logic [3:0]   exp;   // {out, done, ready, busy} after the edge
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int obs();
        return int'({out, done, ready, busy});
    endfunction

    function automatic int obs0();
        return int'({out0, done0, ready0, busy0});
    endfunction

    // Call this at the negedge just after the accept edge. It checks every
    // cycle of the frame and then the IDLE cycle that follows.
    task automatic expect_frame(input logic [W-1:0] d, input string tag);
        logic [2:0] pre;
        logic       o, dn, rd;
        pre = PREAMBLE;
        for (int c = 0; c <= PERIOD; c++) begin
            o  = 1'b0;
            dn = 1'b0;
            rd = (c == PERIOD);
            if (c < PRE_LEN) begin
                o = pre[PRE_LEN-1-c];
            end else if (c < PRE_LEN + W) begin
                o  = d[W-1-(c-PRE_LEN)];
                dn = (c == PRE_LEN + W - 1);
            end
            check($sformatf("%s_c%0d", tag, c), obs(), int'({o, dn, rd, ~rd}));
            if (c < PERIOD) @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        logic [2:0] hist;
        logic [2:0] pre;
        int         hits;
        int         hit_c;

        // Single 8'hA5 frame. The bench changes data_in after the accept and
        // pulses valid with 8'h00 while busy. Neither may alter the stream or
        // start a second frame.
        vecs[0]  = '{1'b1, 8'hA5, 4'b1001};
        vecs[1]  = '{1'b0, 8'h00, 4'b0001};
        vecs[2]  = '{1'b0, 8'h00, 4'b1001};
        vecs[3]  = '{1'b0, 8'h00, 4'b1001};  // bit7 = 1
        vecs[4]  = '{1'b0, 8'h00, 4'b0001};  // bit6 = 0
        vecs[5]  = '{1'b1, 8'h00, 4'b1001};  // bit5 = 1, valid ignored
        vecs[6]  = '{1'b0, 8'h00, 4'b0001};  // bit4 = 0
        vecs[7]  = '{1'b0, 8'h00, 4'b0001};  // bit3 = 0
        vecs[8]  = '{1'b0, 8'h00, 4'b1001};  // bit2 = 1
        vecs[9]  = '{1'b0, 8'h00, 4'b0001};  // bit1 = 0
        vecs[10] = '{1'b0, 8'h00, 4'b1101};  // bit0 = 1, done
        vecs[11] = '{1'b0, 8'h00, 4'b0001};  // gap
        vecs[12] = '{1'b0, 8'h00, 4'b0001};  // gap
        vecs[13] = '{1'b0, 8'h00, 4'b0010};  // ready 13 cycles after accept
        vecs[14] = '{1'b0, 8'h00, 4'b0010};
        vecs[15] = '{1'b0, 8'h00, 4'b0010};

        reset   = 1'b0;
        valid   = 1'b1;
        data_in = 8'hFF;
        valid0  = 1'b0;
        data0   = '0;

        // Hold reset with valid high. No word may be accepted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_hold_%0d", i), obs(), 4'b0010);
            check($sformatf("reset_hold0_%0d", i), obs0(), 4'b0010);
        end

        // Release reset with valid still high. The next edge accepts 8'hFF.
        reset = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        expect_frame(8'hFF, "post_reset_ff");

        // Table-driven A5 frame.
        for (int i = 0; i < 16; i++) begin
            valid   = vecs[i].valid;
            data_in = vecs[i].data;
            @(negedge clk);
            check($sformatf("vec_a5_%0d", i), obs(), int'(vecs[i].exp));
        end

        // Back-to-back frames with valid held high.
        valid   = 1'b1;
        data_in = 8'h3C;
        @(negedge clk);
        data_in = 8'hC3;
        expect_frame(8'h3C, "b2b_3c");
        @(negedge clk);
        valid = 1'b0;
        expect_frame(8'hC3, "b2b_c3");

        // Assert reset during data bit 5, then send a clean frame.
        valid   = 1'b1;
        data_in = 8'hFF;
        @(negedge clk);
        valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_bit5", obs(), 4'b1001);
        reset = 1'b0;
        #1;
        check("mid_reset_async", obs(), 4'b0010);
        @(negedge clk);
        check("mid_reset_hold", obs(), 4'b0010);
        reset   = 1'b1;
        valid   = 1'b1;
        data_in = 8'h81;
        @(negedge clk);
        valid = 1'b0;
        expect_frame(8'h81, "after_reset_81");

        // Loopback check: 8'h00 with no gap. The 101 detector must fire once,
        // on the third preamble bit.
        pre    = PREAMBLE;
        hist   = 3'b000;
        hits   = 0;
        hit_c  = -1;
        valid0 = 1'b1;
        data0  = 8'h00;
        @(negedge clk);
        valid0 = 1'b0;
        for (int c = 0; c < PRE_LEN + W + 4; c++) begin
            hist = {hist[1:0], out0};
            if (hist == pre) begin
                hits++;
                hit_c = c;
            end
            if (c == PRE_LEN + W - 1) check("loop_done", obs0(), 4'b0101);
            if (c == PRE_LEN + W)     check("loop_ready_nogap", obs0(), 4'b0010);
            @(negedge clk);
        end
        check("loop_hits", hits, 1);
        check("loop_hit_cycle", hit_c, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
